// File: rtl/mux_select_arbiter_if.sv
// mux_select_arbiter_if: request/release handshake, grant, select and counter bundle for the mux arbiter
interface mux_select_arbiter_if #(parameter int CNT_W = 8);
  logic req_a;
  logic req_b;
  logic done_a;
  logic done_b;
  logic gnt_a;
  logic gnt_b;
  logic S;
  logic busy;
  logic [CNT_W-1:0] grants_a;
  logic [CNT_W-1:0] grants_b;
  modport master (
    output req_a, req_b, done_a, done_b,
    input  gnt_a, gnt_b, S, busy, grants_a, grants_b
  );
  modport slave (
    input  req_a, req_b, done_a, done_b,
    output gnt_a, gnt_b, S, busy, grants_a, grants_b
  );
endinterface

// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: round-robin two-way arbiter driving a delayed 2:1 mux select,
// with a one-cycle guard gap between owners and per-requester grant counters
module mux_select_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic Reset_L,
  mux_select_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, GUARD} state_t;
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  state_t state;
  logic last;
  logic [7:0] hold;
  logic pick_a, pick_b, at_max, exit_a, exit_b;
  // last=1 means B was granted most recently, so A wins a tie
  always_comb begin
    pick_a = bus.req_a & (~bus.req_b | last);
    pick_b = bus.req_b & (~bus.req_a | ~last);
    at_max = hold == HOLD_MAX;
    exit_a = bus.done_a | ~bus.req_a | (at_max & bus.req_b);
    exit_b = bus.done_b | ~bus.req_b | (at_max & bus.req_a);
  end
  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state <= IDLE;
      last <= 1'b1;
      hold <= '0;
      bus.gnt_a <= 1'b0;
      bus.gnt_b <= 1'b0;
      bus.S <= 1'b0;
      bus.busy <= 1'b0;
      bus.grants_a <= '0;
      bus.grants_b <= '0;
    end else begin
      case (state)
        GRANT_A: begin
          if (exit_a) begin
            state <= GUARD;
            bus.gnt_a <= 1'b0;
          end else if (!at_max) hold <= hold + 8'd1;
        end
        GRANT_B: begin
          if (exit_b) begin
            state <= GUARD;
            bus.gnt_b <= 1'b0;
          end else if (!at_max) hold <= hold + 8'd1;
        end
        default: begin
          if (pick_a) begin
            state <= GRANT_A;
            last <= 1'b0;
            hold <= 8'd1;
            bus.gnt_a <= 1'b1;
            bus.S <= 1'b0;
            bus.busy <= 1'b1;
            bus.grants_a <= bus.grants_a + 1'b1;
          end else if (pick_b) begin
            state <= GRANT_B;
            last <= 1'b1;
            hold <= 8'd1;
            bus.gnt_b <= 1'b1;
            bus.S <= 1'b1;
            bus.busy <= 1'b1;
            bus.grants_b <= bus.grants_b + 1'b1;
          end else begin
            state <= IDLE;
            bus.busy <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mux_select_arbiter.sv
// tb_mux_select_arbiter: directed scenarios plus random traffic against an owner/held-cycles reference model
module tb_mux_select_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, done_a = 1'b0, done_b = 1'b0;
  int total = 0, bad = 0;
  mux_select_arbiter_if #(.CNT_W(8)) bus ();
  mux_select_arbiter_if #(.CNT_W(2)) bus2 ();
  assign bus.req_a = req_a;
  assign bus.req_b = req_b;
  assign bus.done_a = done_a;
  assign bus.done_b = done_b;
  assign bus2.req_a = req_a;
  assign bus2.req_b = req_b;
  assign bus2.done_a = done_a;
  assign bus2.done_b = done_b;
  mux_select_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (.clk(clk), .Reset_L(rst_n), .bus(bus.slave));
  mux_select_arbiter #(.MAX_HOLD(MH), .CNT_W(2)) dut2 (.clk(clk), .Reset_L(rst_n), .bus(bus2.slave));
  always #5 clk = ~clk;

  // Model: who owns the mux (0 none, 1 A, 2 B), how long they have held it,
  // whether a guard cycle is pending, and the grant history.
  int owner = 0, held = 0, cnt_a = 0, cnt_b = 0;
  bit guard = 0, sel = 0, last_was_a = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = 0; held = 0; cnt_a = 0; cnt_b = 0;
      guard = 0; sel = 0; last_was_a = 0;
    end else if (owner != 0) begin
      bit mine_req, mine_done, other_req;
      mine_req = owner == 1 ? req_a : req_b;
      mine_done = owner == 1 ? done_a : done_b;
      other_req = owner == 1 ? req_b : req_a;
      if (mine_done || !mine_req || (held >= MH && other_req)) begin
        owner = 0;
        guard = 1;
      end else held++;
    end else begin
      int win;
      guard = 0;
      win = 0;
      if (req_a && req_b) win = last_was_a ? 2 : 1;
      else if (req_a) win = 1;
      else if (req_b) win = 2;
      if (win != 0) begin
        owner = win;
        held = 1;
        last_was_a = win == 1;
        sel = win == 2;
        if (win == 1) cnt_a++; else cnt_b++;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_a", int'(bus.gnt_a), int'(owner == 1));
      check("gnt_b", int'(bus.gnt_b), int'(owner == 2));
      check("S", int'(bus.S), int'(sel));
      check("busy", int'(bus.busy), int'(owner != 0 || guard));
      check("grants_a", int'(bus.grants_a), cnt_a % 256);
      check("grants_b", int'(bus.grants_b), cnt_b % 256);
      check("grants_a_w2", int'(bus2.grants_a), cnt_a % 4);
      check("grants_b_w2", int'(bus2.grants_b), cnt_b % 4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_a = 0; req_b = 0; done_a = 0; done_b = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    int n;
    int wrap_seq [5] = '{1, 2, 3, 0, 1};
    // reset with no requests: stays idle
    do_reset();
    repeat (10) tick();
    check("idle_busy", int'(bus.busy), 0);
    check("idle_gnt", int'(bus.gnt_a | bus.gnt_b), 0);
    // single requester A
    req_a = 1;
    tick();
    check("single_gnt_a", int'(bus.gnt_a), 1);
    check("single_S", int'(bus.S), 0);
    check("single_cnt", int'(bus.grants_a), 1);
    repeat (3) tick();
    done_a = 1;
    tick();
    done_a = 0; req_a = 0;
    check("single_guard_gnt", int'(bus.gnt_a), 0);
    check("single_guard_busy", int'(bus.busy), 1);
    tick();
    check("single_idle_busy", int'(bus.busy), 0);
    // tie from reset: A, B, A, B, each releasing after 2 cycles
    do_reset();
    req_a = 1; req_b = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check(i % 2 == 0 ? "tie_gnt_a" : "tie_gnt_b", int'(i % 2 == 0 ? bus.gnt_a : bus.gnt_b), 1);
      check("tie_S", int'(bus.S), i % 2);
      tick();
      if (i % 2 == 0) done_a = 1; else done_b = 1;
      tick();
      done_a = 0; done_b = 0;
      check("tie_guard", int'({bus.busy, bus.gnt_a, bus.gnt_b}), 4);
      if (i < 3) tick();
    end
    check("tie_cnt_a", int'(bus.grants_a), 2);
    check("tie_cnt_b", int'(bus.grants_b), 2);
    req_a = 0; req_b = 0;
    tick();
    tick();
    // preemption after MAX_HOLD cycles
    do_reset();
    req_a = 1;
    tick();
    req_b = 1;
    n = 0;
    while (bus.gnt_a && n < 30) begin
      n++;
      tick();
    end
    check("preempt_len", n, MH);
    check("preempt_guard", int'(bus.busy), 1);
    tick();
    check("preempt_gnt_b", int'(bus.gnt_b), 1);
    check("preempt_S", int'(bus.S), 1);
    req_a = 0; req_b = 0;
    tick();
    tick();
    // no preemption when B idle
    do_reset();
    req_a = 1;
    repeat (25) tick();
    check("hold_long", int'(bus.gnt_a), 1);
    req_a = 0;
    tick();
    tick();
    // counter wrap on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_a = 1;
      tick();
      check("wrap_seq", int'(bus2.grants_a), wrap_seq[i]);
      done_a = 1;
      tick();
      done_a = 0; req_a = 0;
      tick();
    end
    // asynchronous reset in the middle of a B grant
    req_b = 1;
    tick();
    check("mid_gnt_b", int'(bus.gnt_b), 1);
    #2 rst_n = 0;
    #1;
    check("async_gnt_b", int'(bus.gnt_b), 0);
    check("async_S", int'(bus.S), 0);
    check("async_busy", int'(bus.busy), 0);
    check("async_cnt", int'(bus.grants_a | bus.grants_b), 0);
    @(posedge clk);
    #1 rst_n = 1;
    req_a = 1; req_b = 1;
    tick();
    check("after_reset_a_first", int'(bus.gnt_a), 1);
    req_a = 0; req_b = 0;
    tick();
    tick();
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      req_a = $urandom_range(0, 9) < 7;
      req_b = $urandom_range(0, 9) < 6;
      done_a = $urandom_range(0, 5) == 0;
      done_b = $urandom_range(0, 5) == 0;
      rst_n = $urandom_range(0, 299) != 0;
      tick();
    end
    rst_n = 1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_select_arbiter.md
# mux_select_arbiter

Round-robin arbiter and sequencer for a shared 2:1 mux datapath (mux_21_delay style cell). Two requesters, A and B, compete for the mux. The block grants one at a time and drives the mux select `S`. It inserts a one-cycle guard gap between grants so the delayed select path settles before the next owner drives data. It also keeps per-requester grant counters for activity and power estimation.

## Interface
Parameters:
- `MAX_HOLD`, default 4: grant cycles after which the owner is preempted, but only if the other side is requesting. Legal range 1..255.
- `CNT_W`, default 8: width of each grant counter.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `Reset_L`  in  1  asynchronous, active-low reset.
- `req_a`  in  1  requester A wants the mux; held high until served.
- `req_b`  in  1  requester B wants the mux.
- `done_a`  in  1  A releases the mux; sampled only while `gnt_a`=1.
- `done_b`  in  1  B releases the mux; sampled only while `gnt_b`=1.
- `gnt_a`  out  1  A owns the mux.
- `gnt_b`  out  1  B owns the mux.
- `S`  out  1  mux select: 0 = A path, 1 = B path.
- `busy`  out  1  high in GRANT_A, GRANT_B and GUARD.
- `grants_a`  out  CNT_W  count of grants issued to A.
- `grants_b`  out  CNT_W  count of grants issued to B.

## Operation
- The block is a four-state FSM: IDLE, GRANT_A, GRANT_B, GUARD. All outputs are registered.
- Reset (async, `Reset_L`=0) forces:
  - state=IDLE
  - `gnt_a`=`gnt_b`=0, `S`=0, `busy`=0
  - `grants_a`=`grants_b`=0
  - priority pointer `last`=B, so A wins the first tie
  - hold counter=0
- Grant decision, evaluated in IDLE and in GUARD:
  - Only `req_a` high: go to GRANT_A.
  - Only `req_b` high: go to GRANT_B.
  - Both high: grant the side that is not `last`.
  - Neither high: go to IDLE.
- Entering GRANT_x:
  - `gnt_x`=1; `S` is set to 0 for A, 1 for B, on the same edge.
  - `last`=x; the hold counter is cleared to 1.
  - `grants_x` increments and wraps modulo 2^CNT_W.
- In GRANT_x, the hold counter increments each cycle and saturates at `MAX_HOLD`. Leave for GUARD on the next edge if any of these holds:
  - `done_x`=1.
  - `req_x`=0.
  - Hold counter = `MAX_HOLD` and the other requester's req=1 (preemption).
- At `MAX_HOLD` with the other side idle, the owner keeps the grant indefinitely.
- GUARD lasts exactly one cycle:
  - `gnt_a`=`gnt_b`=0; `S` holds its previous value; `busy`=1.
  - The next state comes from the grant decision. With round-robin, a still-requesting former owner loses to a waiting opponent.
- `gnt_a` and `gnt_b` are never high together. `S` changes only on an edge entering GRANT_x; it never changes while a grant is high.
- `done_x` outside GRANT_x is ignored.
- Simultaneous `done_x` and preemption: one exit to GUARD, with no double count.

## Timing
- Request latency from IDLE: req sampled high at edge n gives gnt high after edge n.
  - Combinational from state only; no same-cycle grant.
- Release: `done_x` sampled at edge n:
  - edge n: gnt drops, GUARD entered.
  - edge n+1: next grant at the earliest.
- Back-to-back handoff costs one idle cycle on the mux (GUARD).
- Minimum grant length 1 cycle; maximum under contention `MAX_HOLD` cycles.
- Counters update on the same edge the grant rises.
- Reset mid-grant: outputs clear asynchronously, without waiting for `clk`. The first decision is made at the first rising edge after `Reset_L` rises.

## Test plan
- Reset behaviour: `Reset_L`=0, then 1, with no requests.
  - Required: all outputs 0 and state stays IDLE for 10 cycles.
- Single requester:
  - Stimulus: `req_a`=1 at edge 2; `done_a` pulse at edge 6.
  - Required: `gnt_a`=1 during edges 2..6, `S`=0, `grants_a`=1; GUARD at edge 6; IDLE at edge 7.
- Tie with round-robin:
  - Stimulus: `req_a`=`req_b`=1 from reset; each side releases after 2 cycles.
  - Required: grant order A, B, A, B with one GUARD cycle between each; `S` toggles only on grant edges; after 4 grants `grants_a`=`grants_b`=2.
- Preemption, `MAX_HOLD`=4:
  - Stimulus: A holds with no done; B requests 1 cycle after A's grant.
  - Required: `gnt_a` high for exactly 4 cycles, then GUARD, then `gnt_b`=1 with `S`=1.
  - Variant with B idle: A holds for more than 20 cycles without being preempted.
- Counter wrap, `CNT_W`=2:
  - Stimulus: 5 grants to A.
  - Required: `grants_a` sequence 1, 2, 3, 0, 1.
- Reset mid-grant:
  - Stimulus: drop `Reset_L` between clock edges during `gnt_b`.
  - Required: `gnt_b`, `S`, counters and `busy` go to 0 immediately, before the next edge.
  - Then: after release, with both requesting, A is granted first.
